uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester byte arbiter in front of a UART transmitter.
// Accepts one byte at a time from req0/req1 (round-robin on ties), hands it to
// the transmitter with a one-cycle START, then tracks BUSY until it falls.
// If BUSY never rises within TIMEOUT cycles, the byte is dropped and ERR pulses.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   req{0,1}_valid/_data   requester byte offer (held until ready)
//   req{0,1}_ready         accept strobe, high only in the IDLE cycle that accepts
//   tx_status[0]           transmitter BUSY (other bits ignored)
//   tx_control             {6'b0, ENABLE, START}
//   tx_data                byte presented to the transmitter
//   grant_id               index of the requester last accepted
//   err                    one-cycle pulse when the BUSY wait times out
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  input  logic [7:0] tx_status,
  output logic [7:0] tx_control,
  output logic [7:0] tx_data,
  output logic       grant_id,
  output logic       err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [7:0]       data_q, data_d;
  logic             grant_q, grant_d;
  logic             start_q;
  logic             enable_q;
  logic             err_q, err_d;
  logic             accept;
  logic             pick1;
  logic             busy;
  logic             unused_status;

  assign busy          = tx_status[0];
  assign unused_status = ^tx_status[7:1];

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      data_q   <= 8'h00;
      grant_q  <= 1'b0;
      start_q  <= 1'b0;
      enable_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      start_q  <= accept;
      enable_q <= 1'b1;
      err_q    <= err_d;
    end
  end

  // Arbitration, handshake and next-state logic.
  // READY is a same-cycle response to VALID so it can only ever appear in IDLE;
  // it is gated by rst so nothing is offered while the block is held in reset.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    data_d     = data_q;
    grant_d    = grant_q;
    err_d      = 1'b0;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    // On a tie pick the requester that was not served last
    pick1 = req1_valid & (~req0_valid | ~last_q);

    case (state_q)
      IDLE: begin
        if (!rst && !busy && (req0_valid || req1_valid)) begin
          accept     = 1'b1;
          req0_ready = ~pick1;
          req1_ready = pick1;
          data_d     = pick1 ? req1_data : req0_data;
          grant_d    = pick1;
          last_d     = pick1;
          state_d    = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q >= CNT_LAST) begin
          // Transmitter never picked the byte up: drop it
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx_control = {6'b000000, enable_q, start_q};
  assign tx_data    = data_q;
  assign grant_id   = grant_q;
  assign err        = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single request, timeout, BUSY stuck in
// IDLE, contention, withdrawal and reset during a transfer.
module tb_uart_tx_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic [7:0] tx_status;
  logic [7:0] tx_control;
  logic [7:0] tx_data;
  logic       grant_id;
  logic       err;

  int total;
  int bad;

  uart_tx_arbiter #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx_status  (tx_status),
    .tx_control (tx_control),
    .tx_data    (tx_data),
    .grant_id   (grant_id),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%02h exp=%02h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock, then drive this cycle's inputs; upper status bits carry junk
  task automatic cyc(input logic v0, input logic [7:0] d0, input logic v1,
                     input logic [7:0] d1, input logic busy);
    @(posedge clk);
    #1;
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    tx_status  = {7'h55, busy};
    #1;
  endtask

  // One full transfer with requesters holding their inputs throughout
  task automatic serve(input logic v0, input logic [7:0] d0, input logic v1,
                       input logic [7:0] d1, input logic id, input int dly, input int len);
    logic [7:0] exp_d;
    exp_d = id ? d1 : d0;
    cyc(v0, d0, v1, d1, 1'b0);
    check("acc_r0", 8'(req0_ready), 8'(!id));
    check("acc_r1", 8'(req1_ready), 8'(id));
    cyc(v0, d0, v1, d1, 1'b0);
    check("start_ctl", tx_control, 8'h03);
    check("start_data", tx_data, exp_d);
    check("start_gnt", 8'(grant_id), 8'(id));
    check("start_rdy", 8'({req0_ready, req1_ready}), 8'h00);
    for (int i = 0; i < dly - 1; i++) begin
      cyc(v0, d0, v1, d1, 1'b0);
      check("wb_ctl", tx_control, 8'h02);
      check("wb_rdy", 8'({req0_ready, req1_ready}), 8'h00);
    end
    for (int i = 0; i < len; i++) begin
      cyc(v0, d0, v1, d1, 1'b1);
      check("busy_ctl", tx_control, 8'h02);
      check("busy_rdy", 8'({req0_ready, req1_ready}), 8'h00);
    end
    cyc(v0, d0, v1, d1, 1'b0);
    check("done_rdy", 8'({req0_ready, req1_ready}), 8'h00);
    check("done_data", tx_data, exp_d);
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b1;
    req0_valid = 1'b0;
    req0_data  = 8'h00;
    req1_valid = 1'b0;
    req1_data  = 8'h00;
    tx_status  = 8'h00;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl", tx_control, 8'h00);
    check("rst_data", tx_data, 8'h00);
    check("rst_gnt", 8'(grant_id), 8'h00);
    check("rst_err", 8'(err), 8'h00);
    check("rst_rdy", 8'({req0_ready, req1_ready}), 8'h00);
    rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("rel_ctl", tx_control, 8'h02);

    // Single request: BUSY two cycles after START, held 10 cycles
    serve(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 2, 10);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("t1_idle_ctl", tx_control, 8'h02);
    check("t1_idle_data", tx_data, 8'hA5);

    // Timeout: BUSY never rises
    cyc(1'b0, 8'h00, 1'b1, 8'h3C, 1'b0);
    check("to_acc_r1", 8'(req1_ready), 8'h01);
    check("to_acc_r0", 8'(req0_ready), 8'h00);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("to_start_ctl", tx_control, 8'h03);
    check("to_start_gnt", 8'(grant_id), 8'h01);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      check("to_wait_err", 8'(err), 8'h00);
      check("to_wait_ctl", tx_control, 8'h02);
    end
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("to_err", 8'(err), 8'h01);
    check("to_err_data", tx_data, 8'h3C);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("to_err_end", 8'(err), 8'h00);
    serve(1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 1, 3);

    // BUSY stuck high in IDLE
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 8'h99, 1'b1);
      check("stuck_rdy", 8'({req0_ready, req1_ready}), 8'h00);
      check("stuck_data", tx_data, 8'h77);
    end
    serve(1'b0, 8'h00, 1'b1, 8'h99, 1'b1, 2, 2);

    // Contention: last served was requester 1, so 0 wins first
    serve(1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1, 2);
    serve(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1, 2);
    serve(1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1, 2);
    serve(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1, 2);

    // Withdrawal: req0 offers during the transfer and drops in WAIT_DONE
    cyc(1'b0, 8'h00, 1'b1, 8'h5A, 1'b0);
    check("wd_acc_r1", 8'(req1_ready), 8'h01);
    cyc(1'b1, 8'hC3, 1'b1, 8'h6B, 1'b0);
    check("wd_start_data", tx_data, 8'h5A);
    cyc(1'b1, 8'hC3, 1'b1, 8'h6B, 1'b1);
    check("wd_wb_rdy", 8'({req0_ready, req1_ready}), 8'h00);
    cyc(1'b0, 8'h00, 1'b1, 8'h6B, 1'b1);
    check("wd_done_rdy", 8'({req0_ready, req1_ready}), 8'h00);
    cyc(1'b0, 8'h00, 1'b1, 8'h6B, 1'b0);
    check("wd_done0_rdy", 8'({req0_ready, req1_ready}), 8'h00);
    cyc(1'b0, 8'h00, 1'b1, 8'h6B, 1'b0);
    check("wd_next_r1", 8'(req1_ready), 8'h01);
    check("wd_next_r0", 8'(req0_ready), 8'h00);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("wd_start_data2", tx_data, 8'h6B);
    check("wd_start_gnt", 8'(grant_id), 8'h01);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("wd_idle_rdy", 8'({req0_ready, req1_ready}), 8'h00);

    // Reset pulsed during WAIT_DONE
    cyc(1'b1, 8'hE7, 1'b0, 8'h00, 1'b0);
    check("rs_acc_r0", 8'(req0_ready), 8'h01);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    check("rs_start_ctl", tx_control, 8'h03);
    cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'hE8, 1'b0, 8'h00, 1'b1);
    check("rs_wd_rdy", 8'(req0_ready), 8'h00);
    #2;
    rst       = 1'b1;
    tx_status = 8'h00;
    #1;
    check("rs_async_ctl", tx_control, 8'h00);
    check("rs_async_data", tx_data, 8'h00);
    check("rs_async_gnt", 8'(grant_id), 8'h00);
    check("rs_async_err", 8'(err), 8'h00);
    check("rs_async_rdy", 8'(req0_ready), 8'h00);
    repeat (2) @(posedge clk);
    #1;
    check("rs_hold_ctl", tx_control, 8'h00);
    rst        = 1'b0;
    req0_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      check("rs_rel_ctl", tx_control, 8'h02);
      check("rs_rel_err", 8'(err), 8'h00);
    end
    // Tie priority is back to requester 0 after reset
    serve(1'b1, 8'h31, 1'b1, 8'h42, 1'b0, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
